// File: rtl/fpga_mem_dmaster_st_arbiter.sv
// Packet-locked round-robin arbiter for the EMIF debug master Avalon-ST byte channel.
// Ports: clk, reset (sync, active-high); per-source in_valid/in_data/in_sop/in_eop/in_ready;
//   registered out_valid/out_data/out_sop/out_eop with out_ready backpressure;
//   grant (one-hot owner, 0 when idle); timeout_err (sticky).
// Optional: define DMASTER_ARB_TIMEOUT_EN to drop a stalled owner after TIMEOUT_CYC idle cycles.
module fpga_mem_dmaster_st_arbiter #(
    parameter int NUM_SRC     = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     in_valid,
    input  logic [8*NUM_SRC-1:0]   in_data,
    input  logic [NUM_SRC-1:0]     in_sop,
    input  logic [NUM_SRC-1:0]     in_eop,
    output logic [NUM_SRC-1:0]     in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   out_sop,
    output logic                   out_eop,
    input  logic                   out_ready,
    output logic [NUM_SRC-1:0]     grant,
    output logic                   timeout_err
);

    localparam int IW = (NUM_SRC > 2) ? 2 : 1;

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] own_q, own_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] pick;
    logic          found;
    int            idx;

    logic          own_valid;
    logic          own_sop;
    logic          own_eop;
    logic [7:0]    own_data;
    logic          stage_free;
    logic          accept;
    logic          tmo;

    // Scan starting just after the previous owner, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_q) + k) % NUM_SRC;
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign own_valid  = in_valid[own_q];
    assign own_sop    = in_sop[own_q];
    assign own_eop    = in_eop[own_q];
    assign own_data   = in_data[8*own_q +: 8];
    assign stage_free = !out_valid || out_ready;
    assign accept     = (state_q == PKT) && own_valid && stage_free;

    always_comb begin
        grant    = '0;
        in_ready = '0;
        if (state_q == PKT) begin
            grant[own_q]    = 1'b1;
            in_ready[own_q] = stage_free;
        end
    end

`ifdef DMASTER_ARB_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        tmo_err_q;

    // Counts consecutive owner-idle cycles; tmo fires on the edge it reaches the limit.
    assign tmo = (state_q == PKT) && !own_valid
               && (idle_cnt == 16'(TIMEOUT_CYC - 1));
    assign timeout_err = tmo_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt  <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (state_q != PKT || own_valid || tmo) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end
            if (tmo) begin
                tmo_err_q <= 1'b1;
            end
        end
    end
`else
    localparam int unused_tmo = TIMEOUT_CYC;
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = PKT;
                    own_d   = pick;
                end
            end
            PKT: begin
                if ((accept && own_eop) || tmo) begin
                    state_d = IDLE;
                    last_d  = own_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            own_q     <= '0;
            last_q    <= IW'(NUM_SRC - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            // A new accept overwrites a byte that drains on this same edge.
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= own_data;
                out_sop   <= own_sop;
                out_eop   <= own_eop;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpga_mem_dmaster_st_arbiter.sv
// Self-checking bench for fpga_mem_dmaster_st_arbiter.
// Expected output stream is packets in strict round-robin order.
module tb_fpga_mem_dmaster_st_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_sop;
    logic [1:0]  in_eop;
    logic [1:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_ready;
    logic [1:0]  grant;
    logic        timeout_err;

    fpga_mem_dmaster_st_arbiter #(
        .NUM_SRC     (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_ready   (out_ready),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t src_q[2][$];
    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packets must be added in round-robin order: exp_q is the model output.
    task automatic add_pkt(input int s, input int len,
                           input logic [7:0] base, input bit rnd);
        for (int b = 0; b < len; b++) begin
            beat_t x;
            x.d   = rnd ? 8'($urandom) : base + 8'(b);
            x.sop = (b == 0);
            x.eop = (b == len - 1);
            src_q[s].push_back(x);
            exp_q.push_back(x);
        end
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int max_cyc, input int rdy_pct, input bit gaps);
        int         cyc = 0;
        bit [1:0]   fire = '0;
        bit         hold = 1'b0;
        logic [7:0] pd = '0;
        logic       ps = 1'b0;
        logic       pe = 1'b0;
        while (exp_q.size() > 0 && cyc < max_cyc) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (fire[s]) void'(src_q[s].pop_front());
                if (src_q[s].size() > 0) begin
                    in_data[8*s +: 8] = src_q[s][0].d;
                    in_sop[s]         = src_q[s][0].sop;
                    in_eop[s]         = src_q[s][0].eop;
                    in_valid[s]       = (src_q[s][0].sop || !gaps) ? 1'b1
                                      : ($urandom_range(0, 99) < 75);
                end else begin
                    in_data[8*s +: 8] = '0;
                    in_sop[s]         = 1'b0;
                    in_eop[s]         = 1'b0;
                    in_valid[s]       = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            #1;
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            chk("in_ready", 32'(in_ready),
                32'(grant & {2{!out_valid || out_ready}}));
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(pd));
                chk("hold_sopeop", {30'd0, out_sop, out_eop}, {30'd0, ps, pe});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'd1, 32'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("out_beat", {22'd0, out_data, out_sop, out_eop},
                        {22'd0, e.d, e.sop, e.eop});
                end
            end
            for (int s = 0; s < 2; s++) fire[s] = in_valid[s] && in_ready[s];
            hold = out_valid && !out_ready;
            pd   = out_data;
            ps   = out_sop;
            pe   = out_eop;
            cyc++;
        end
        chk("run_done", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        src_q[0].delete();
        src_q[1].delete();
        @(negedge clk);
        idle_inputs();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        idle_inputs();

        // Reset state
        do_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);

        // Two sources, three rounds, fixed data
        for (int r = 0; r < 3; r++) begin
            add_pkt(0, 3, 8'hA0, 1'b0);
            add_pkt(1, 3, 8'hB0, 1'b0);
        end
        run(60, 100, 1'b0);

        // Single-beat packet on src1
        do_reset();
        in_valid = 2'b10;
        in_data  = 16'h5A00;
        in_sop   = 2'b10;
        in_eop   = 2'b10;
        #1;
        chk("sb_grant_t", 32'(grant), 32'd0);
        @(negedge clk);
        #1;
        chk("sb_grant_t1", 32'(grant), 32'b10);
        chk("sb_ready_t1", 32'(in_ready), 32'b10);
        chk("sb_valid_t1", 32'(out_valid), 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("sb_valid_t2", 32'(out_valid), 32'd1);
        chk("sb_beat_t2", {22'd0, out_data, out_sop, out_eop},
            {22'd0, 8'h5A, 1'b1, 1'b1});
        chk("sb_grant_t2", 32'(grant), 32'd0);

        // Randomised traffic with backpressure and source bubbles
        do_reset();
        for (int p = 0; p < 12; p++) begin
            add_pkt(0, $urandom_range(1, 6), 8'h00, 1'b1);
            add_pkt(1, $urandom_range(1, 6), 8'h00, 1'b1);
        end
        run(2000, 60, 1'b1);

        // Reset in the middle of a 4-byte packet
        do_reset();
        in_valid = 2'b01;
        in_data  = 16'h00D0;
        in_sop   = 2'b01;
        @(negedge clk);
        #1;
        chk("mr_grant", 32'(grant), 32'b01);
        @(negedge clk);
        #1;
        chk("mr_byte0", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hD0});
        in_data = 16'h00D1;
        in_sop  = 2'b00;
        @(negedge clk);
        in_data = 16'h00D2;
        reset   = 1'b1;
        @(negedge clk);
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_out_beat", {22'd0, out_data, out_sop, out_eop}, 32'd0);
        chk("mr_grant_clr", 32'(grant), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        idle_inputs();
        add_pkt(0, 2, 8'hC0, 1'b0);
        run(20, 100, 1'b0);

`ifdef DMASTER_ARB_TIMEOUT_EN
        // Owner stalls after its sop byte; src1 waits
        do_reset();
        in_valid = 2'b11;
        in_data  = 16'h2211;
        in_sop   = 2'b11;
        in_eop   = 2'b10;
        @(negedge clk);
        #1;
        chk("to_grant0", 32'(grant), 32'b01);
        @(negedge clk);
        in_valid = 2'b10;
        repeat (7) @(negedge clk);
        #1;
        chk("to_hold", 32'(grant), 32'b01);
        chk("to_err_pre", 32'(timeout_err), 32'd0);
        @(negedge clk);
        #1;
        chk("to_drop", 32'(grant), 32'd0);
        chk("to_err", 32'(timeout_err), 32'd1);
        @(negedge clk);
        #1;
        chk("to_next", 32'(grant), 32'b10);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("to_beat", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h22});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
